// File: rtl/conv_arbiter.sv
// Two-client arbiter for one shared 8-bit converter: one full soc/eoc conversion
// per grant, result returned on a shared data bus, ties broken round-robin.
module conv_arbiter (
  input  logic       clock,
  input  logic       reset_,
  output logic       soc,
  input  logic       eoc,
  input  logic [7:0] x,
  input  logic       req1,
  input  logic       req2,
  output logic       ack1,
  output logic       ack2,
  output logic [7:0] data
);
  typedef enum logic [1:0] {IDLE, START, WAIT, ACK} state_t;

  state_t     star, star_n;
  // client encoding for g/last: 0 = client 1, 1 = client 2
  logic       g, g_n, last, last_n;
  logic       soc_n, ack1_n, ack2_n;
  logic [7:0] data_n;
  logic       req_g, grant_ok;

  assign req_g    = g ? req2 : req1;
  assign grant_ok = eoc && (req1 || req2);

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      star <= IDLE;
      g    <= 1'b0;
      last <= 1'b1;
      data <= 8'h00;
      soc  <= 1'b0;
      ack1 <= 1'b0;
      ack2 <= 1'b0;
    end else begin
      star <= star_n;
      g    <= g_n;
      last <= last_n;
      data <= data_n;
      soc  <= soc_n;
      ack1 <= ack1_n;
      ack2 <= ack2_n;
    end
  end

  always_comb begin
    star_n = star;
    g_n    = g;
    case (star)
      IDLE: if (grant_ok) begin
        star_n = START;
        // contested: the client not served last wins
        g_n    = (req1 && req2) ? ~last : req2;
      end
      START:   if (!eoc)  star_n = WAIT;
      WAIT:    if (eoc)   star_n = ACK;
      ACK:     if (!req_g) star_n = IDLE;
      default: star_n = IDLE;
    endcase
  end

  always_comb begin
    soc_n  = soc;
    ack1_n = ack1;
    ack2_n = ack2;
    data_n = data;
    last_n = last;
    case (star)
      IDLE:  if (grant_ok) soc_n = 1'b1;
      START: if (!eoc) soc_n = 1'b0;
      WAIT: if (eoc) begin
        data_n = x;
        if (g) ack2_n = 1'b1;
        else   ack1_n = 1'b1;
      end
      ACK: if (!req_g) begin
        ack1_n = 1'b0;
        ack2_n = 1'b0;
        last_n = g;
      end
      default: ;
    endcase
  end
endmodule
